// File: rtl/mips_pkg.sv
// Shared MIPS constants: opcode/funct values used to recognise control
// instructions, the NOP encoding injected as a bubble, and the fetch
// state encoding.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] FUNCT_JR = 6'b001000;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    // RUN: fetching normally. WAIT_RESOLVE: a control instruction is in
    // flight and fetch is parked until WB returns the next PC.
    typedef enum logic {
        RUN          = 1'b0,
        WAIT_RESOLVE = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/ctrl_instr_detect.sv
// Combinational decode flagging instructions that change control flow
// (beq, bne, j, jal, jr). Takes only the opcode and funct fields so it can
// be shared with the hazard unit without dragging the whole word along.
module ctrl_instr_detect
    import mips_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output logic       is_control
);

    // Opcode decode; jr is the only R-type that redirects.
    always_comb begin
        is_control = 1'b0;
        case (opcode)
            OP_BEQ, OP_BNE, OP_J, OP_JAL: is_control = 1'b1;
            OP_RTYPE:                     is_control = (funct == FUNCT_JR);
            default:                      is_control = 1'b0;
        endcase
    end

endmodule

// File: rtl/if_fetch_control_unit.sv
// Instruction-fetch front end. Holds the PC and the IF/ID pipeline register.
// Branches and jumps resolve only in WB, so after fetching a control
// instruction this block parks, feeds NOP bubbles to decode, and resumes at
// the PC that WB sends back on redirect.
module if_fetch_control_unit
    import mips_pkg::*;
#(
    parameter int          NBits       = 32,
    parameter logic [31:0] RESET_PC    = 32'h0040_0000,
    parameter int          COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   stall,
    input  logic                   redirect_valid,
    input  logic [NBits-1:0]       redirect_pc,
    output logic [NBits-1:0]       imem_addr,
    input  logic [NBits-1:0]       imem_rdata,
    output logic [NBits-1:0]       out_PC_4,
    output logic [NBits-1:0]       out_Instruction,
    output logic                   out_Valid,
    output logic                   waiting,
    output logic [COUNT_WIDTH-1:0] bubble_count
);

    fetch_state_t           state_reg;
    logic [NBits-1:0]       pc_reg;
    logic [NBits-1:0]       pc_plus4;
    logic                   fetched_is_control;

    // PC+4 wraps naturally at the NBits boundary.
    assign pc_plus4  = pc_reg + NBits'(4);
    assign imem_addr = pc_reg;
    assign waiting   = (state_reg == WAIT_RESOLVE);

    ctrl_instr_detect u_detect (
        .opcode     (imem_rdata[31:26]),
        .funct      (imem_rdata[5:0]),
        .is_control (fetched_is_control)
    );

    // PC, fetch state, IF/ID register and bubble counter. Redirect wins over
    // both stall (for PC/state) and a normal fetch; a bubble keeps the last
    // PC+4 so decode still sees a sensible link value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg       <= RUN;
            pc_reg          <= RESET_PC[NBits-1:0];
            out_PC_4        <= '0;
            out_Instruction <= '0;
            out_Valid       <= 1'b0;
            bubble_count    <= '0;
        end else if (redirect_valid) begin
            pc_reg    <= redirect_pc;
            state_reg <= RUN;
            if (!stall) begin
                out_Instruction <= NBits'(NOP_INSTR);
                out_Valid       <= 1'b0;
                if (bubble_count != '1)
                    bubble_count <= bubble_count + 1'b1;
            end
        end else if (state_reg == RUN) begin
            if (!stall) begin
                out_PC_4        <= pc_plus4;
                out_Instruction <= imem_rdata;
                out_Valid       <= 1'b1;
                pc_reg          <= pc_plus4;
                if (fetched_is_control)
                    state_reg <= WAIT_RESOLVE;
            end
        end else begin
            if (!stall) begin
                out_Instruction <= NBits'(NOP_INSTR);
                out_Valid       <= 1'b0;
                if (bubble_count != '1)
                    bubble_count <= bubble_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_if_fetch_control_unit.sv
// Directed bench for if_fetch_control_unit: straight-line fetch, beq and jr
// resolution, stall interaction, redirect in RUN, async reset mid-wait,
// PC wrap, and bubble counter saturation on a narrow-counter instance.
module tb_if_fetch_control_unit;

    localparam logic [31:0] RPC      = 32'h0040_0000;
    localparam logic [31:0] ADDI1    = 32'h2001_0001;
    localparam logic [31:0] ADDI2    = 32'h2002_0002;
    localparam logic [31:0] ADDI3    = 32'h2003_0003;
    localparam logic [31:0] ADDI_DEF = 32'h2000_0000;
    localparam logic [31:0] BEQ      = 32'h1000_0007;
    localparam logic [31:0] JR       = 32'h03E0_0008;
    localparam logic [31:0] JMP      = 32'h0810_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] out_PC_4;
    logic [31:0] out_Instruction;
    logic        out_Valid;
    logic        waiting;
    logic [15:0] bubble_count;

    logic [31:0] s_imem_addr;
    logic [31:0] s_out_PC_4;
    logic [31:0] s_out_Instruction;
    logic        s_out_Valid;
    logic        s_waiting;
    logic [1:0]  s_bubble_count;

    logic [31:0] rom [0:63];

    int tests_run = 0;
    int fails     = 0;

    always #5 clk = ~clk;

    // Combinational instruction memory: 256-byte window at RESET_PC.
    always_comb begin
        imem_rdata = ADDI_DEF;
        if (imem_addr[31:8] == RPC[31:8])
            imem_rdata = rom[imem_addr[7:2]];
    end

    if_fetch_control_unit dut (
        .clk             (clk),
        .reset           (reset),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .imem_addr       (imem_addr),
        .imem_rdata      (imem_rdata),
        .out_PC_4        (out_PC_4),
        .out_Instruction (out_Instruction),
        .out_Valid       (out_Valid),
        .waiting         (waiting),
        .bubble_count    (bubble_count)
    );

    // Same stimulus, 2-bit counter to reach saturation quickly.
    if_fetch_control_unit #(.COUNT_WIDTH(2)) dut_sat (
        .clk             (clk),
        .reset           (reset),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .imem_addr       (s_imem_addr),
        .imem_rdata      (imem_rdata),
        .out_PC_4        (s_out_PC_4),
        .out_Instruction (s_out_Instruction),
        .out_Valid       (s_out_Valid),
        .waiting         (s_waiting),
        .bubble_count    (s_bubble_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock; inputs and samples both sit 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
        $display("[TB] t=%0t addr=%h if_pc4=%h if_instr=%h v=%0b wait=%0b bub=%0d",
                 $time, imem_addr, out_PC_4, out_Instruction, out_Valid, waiting, bubble_count);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) rom[i] = ADDI_DEF;
        rom[0] = ADDI1; rom[1] = ADDI2; rom[2] = ADDI3;
        stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;

        // Reset state
        reset = 1'b1;
        step();
        check("rst_addr",  imem_addr, RPC);
        check("rst_valid", 32'(out_Valid), 32'd0);
        check("rst_instr", out_Instruction, 32'd0);
        check("rst_pc4",   out_PC_4, 32'd0);
        check("rst_wait",  32'(waiting), 32'd0);
        check("rst_bub",   32'(bubble_count), 32'd0);
        reset = 1'b0;

        // Straight-line fetch of three ALU instructions
        check("sl_addr0", imem_addr, RPC);
        step();
        check("sl_instr0", out_Instruction, ADDI1);
        check("sl_pc4_0",  out_PC_4, RPC + 32'd4);
        check("sl_valid0", 32'(out_Valid), 32'd1);
        check("sl_addr1",  imem_addr, RPC + 32'd4);
        step();
        check("sl_instr1", out_Instruction, ADDI2);
        check("sl_addr2",  imem_addr, RPC + 32'd8);
        step();
        check("sl_instr2", out_Instruction, ADDI3);
        check("sl_pc4_2",  out_PC_4, RPC + 32'd12);
        check("sl_valid2", 32'(out_Valid), 32'd1);
        check("sl_bub",    32'(bubble_count), 32'd0);

        // Taken beq at +4, redirect to +0x20 after four bubbles
        rom[1] = BEQ; rom[8] = 32'h2004_0004; rom[9] = JR; rom[16] = 32'h2005_0005;
        rom[12] = 32'h2006_0006; rom[13] = JMP;
        do_reset();
        step();
        check("beq_pre", out_Instruction, ADDI1);
        step();
        check("beq_instr", out_Instruction, BEQ);
        check("beq_wait",  32'(waiting), 32'd1);
        check("beq_addr",  imem_addr, RPC + 32'd8);
        for (int k = 1; k <= 4; k++) begin
            step();
            check($sformatf("beq_bub%0d_valid", k), 32'(out_Valid), 32'd0);
            check($sformatf("beq_bub%0d_instr", k), out_Instruction, 32'd0);
            check($sformatf("beq_bub%0d_pc4", k),   out_PC_4, RPC + 32'd8);
            check($sformatf("beq_bub%0d_cnt", k),   32'(bubble_count), 32'(k));
            check($sformatf("beq_bub%0d_wait", k),  32'(waiting), 32'd1);
            check($sformatf("beq_bub%0d_addr", k),  imem_addr, RPC + 32'd8);
        end
        check("sat_cnt3", 32'(s_bubble_count), 32'd3);
        redirect_valid = 1'b1; redirect_pc = RPC + 32'h20;
        step();
        redirect_valid = 1'b0;
        check("beq_redir_cnt",  32'(bubble_count), 32'd5);
        check("beq_redir_wait", 32'(waiting), 32'd0);
        check("beq_redir_addr", imem_addr, RPC + 32'h20);
        check("beq_redir_val",  32'(out_Valid), 32'd0);
        check("sat_cnt_hold",   32'(s_bubble_count), 32'd3);
        step();
        check("beq_tgt_instr", out_Instruction, 32'h2004_0004);
        check("beq_tgt_pc4",   out_PC_4, RPC + 32'h24);
        check("beq_tgt_valid", 32'(out_Valid), 32'd1);

        // jr with stall held two cycles while waiting
        step();
        check("jr_instr", out_Instruction, JR);
        check("jr_wait",  32'(waiting), 32'd1);
        stall = 1'b1;
        step();
        step();
        check("jr_stall_cnt",   32'(bubble_count), 32'd5);
        check("jr_stall_instr", out_Instruction, JR);
        check("jr_stall_valid", 32'(out_Valid), 32'd1);
        check("jr_stall_wait",  32'(waiting), 32'd1);
        stall = 1'b0;
        step();
        check("jr_bub_cnt",   32'(bubble_count), 32'd6);
        check("jr_bub_valid", 32'(out_Valid), 32'd0);
        redirect_valid = 1'b1; redirect_pc = RPC + 32'h40;
        step();
        redirect_valid = 1'b0;
        check("jr_redir_cnt",  32'(bubble_count), 32'd7);
        check("jr_redir_addr", imem_addr, RPC + 32'h40);
        step();
        check("jr_tgt_instr", out_Instruction, 32'h2005_0005);
        check("jr_tgt_pc4",   out_PC_4, RPC + 32'h44);

        // Redirect together with stall while in RUN
        stall = 1'b1; redirect_valid = 1'b1; redirect_pc = RPC + 32'h30;
        step();
        stall = 1'b0; redirect_valid = 1'b0;
        check("rs_addr",  imem_addr, RPC + 32'h30);
        check("rs_instr", out_Instruction, 32'h2005_0005);
        check("rs_pc4",   out_PC_4, RPC + 32'h44);
        check("rs_valid", 32'(out_Valid), 32'd1);
        check("rs_wait",  32'(waiting), 32'd0);
        check("rs_cnt",   32'(bubble_count), 32'd7);
        step();
        check("rs_next_instr", out_Instruction, 32'h2006_0006);
        check("rs_next_pc4",   out_PC_4, RPC + 32'h34);

        // Asynchronous reset in WAIT_RESOLVE, between clock edges
        step();
        check("ar_instr", out_Instruction, JMP);
        check("ar_wait",  32'(waiting), 32'd1);
        step();
        check("ar_cnt", 32'(bubble_count), 32'd8);
        #3 reset = 1'b1;
        #1;
        check("ar_wait0", 32'(waiting), 32'd0);
        check("ar_valid", 32'(out_Valid), 32'd0);
        check("ar_addr",  imem_addr, RPC);
        check("ar_cnt0",  32'(bubble_count), 32'd0);
        step();
        reset = 1'b0;

        // Redirect in RUN to top of address space, then PC+4 wraps to 0
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        step();
        redirect_valid = 1'b0;
        check("wr_addr",  imem_addr, 32'hFFFF_FFFC);
        check("wr_cnt",   32'(bubble_count), 32'd1);
        check("wr_valid", 32'(out_Valid), 32'd0);
        step();
        check("wr_pc4",   out_PC_4, 32'd0);
        check("wr_addr0", imem_addr, 32'd0);
        check("wr_instr", out_Instruction, ADDI_DEF);
        check("wr_valid1", 32'(out_Valid), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
